cache_refill_resp: RTL

//  Memory-side responder for cache line refills. Accepts one miss request (byte address) from the

---
 rtl/cache_refill_resp_if.sv | 36 +++
 rtl/cache_refill_resp.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/cache_refill_resp_if.sv
// Refill responder bus: request, backing-memory read and response channels.
// Signal suffixes are from the responder's point of view.
interface cache_refill_resp_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 4
);
    localparam int unsigned IW = $clog2(LINE_WORDS);

    logic                  req_vld_i;
    logic                  req_rdy_o;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic                  mem_re_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  rsp_vld_o;
    logic                  rsp_rdy_i;
    logic [DATA_WIDTH-1:0] rsp_data_o;
    logic [IW-1:0]         rsp_idx_o;
    logic                  rsp_last_o;
    logic                  ack_o;

    // Responder side.
    modport slave (
        input  req_vld_i, req_addr_i, mem_rdata_i, rsp_rdy_i,
        output req_rdy_o, mem_re_o, mem_addr_o, rsp_vld_o, rsp_data_o, rsp_idx_o,
               rsp_last_o, ack_o
    );

    // Cache controller / memory side.
    modport master (
        output req_vld_i, req_addr_i, mem_rdata_i, rsp_rdy_i,
        input  req_rdy_o, mem_re_o, mem_addr_o, rsp_vld_o, rsp_data_o, rsp_idx_o,
               rsp_last_o, ack_o
    );
endinterface

// File: rtl/cache_refill_resp.sv
// Cache line refill responder: reads a line critical-word-first from a fixed-latency
// memory, streams it as beats through a small FIFO, then pulses ack.
module cache_refill_resp #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned MEM_LAT    = 2
) (
    input logic                clk,
    input logic                reset,
    cache_refill_resp_if.slave bus
);
    localparam int unsigned OFF = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IW  = $clog2(LINE_WORDS);
    localparam int unsigned FD  = MEM_LAT + 2;
    localparam int unsigned PW  = $clog2(FD);
    localparam int unsigned CW  = $clog2(FD + 1);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StAck} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [IW-1:0]         rd_idx_q;
    logic [IW-1:0]         issued_q;
    logic [IW-1:0]         beat_q;

    logic [MEM_LAT-1:0]    sr_vld_q;
    logic [IW-1:0]         sr_idx_q   [MEM_LAT];
    logic [DATA_WIDTH-1:0] fifo_data_q[FD];
    logic [IW-1:0]         fifo_idx_q [FD];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         cnt_q;

    logic        issue;
    logic        push;
    logic        pop;
    logic        rsp_vld;
    logic        last_beat;
    int unsigned occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    // Read issue gating: FIFO entries plus reads still in flight must leave room.
    always_comb begin
        occ = 32'(cnt_q);
        for (int i = 0; i < int'(MEM_LAT); i++) begin
            occ = occ + 32'(sr_vld_q[i]);
        end
        issue     = (state_q == StFetch) && (occ < FD);
        push      = sr_vld_q[MEM_LAT-1];
        rsp_vld   = (cnt_q != '0);
        pop       = rsp_vld && bus.rsp_rdy_i;
        last_beat = (beat_q == IW'(LINE_WORDS - 1));
    end

    assign bus.req_rdy_o  = (state_q == StIdle);
    assign bus.mem_re_o   = issue;
    assign bus.mem_addr_o = base_q | (ADDR_WIDTH'(rd_idx_q) << OFF);
    assign bus.rsp_vld_o  = rsp_vld;
    assign bus.rsp_data_o = fifo_data_q[rd_ptr_q];
    assign bus.rsp_idx_o  = fifo_idx_q[rd_ptr_q];
    assign bus.rsp_last_o = rsp_vld && last_beat;
    assign bus.ack_o      = (state_q == StAck);

    // Control FSM: accept, issue the line's reads, wait for the last beat, acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            base_q   <= '0;
            rd_idx_q <= '0;
            issued_q <= '0;
            beat_q   <= '0;
        end else begin
            if (pop) begin
                beat_q <= beat_q + IW'(1);
            end
            case (state_q)
                StIdle: begin
                    if (bus.req_vld_i) begin
                        base_q   <= bus.req_addr_i &
                                    ~((ADDR_WIDTH'(1) << (OFF + IW)) - ADDR_WIDTH'(1));
                        rd_idx_q <= bus.req_addr_i[OFF+IW-1:OFF];
                        issued_q <= '0;
                        beat_q   <= '0;
                        state_q  <= StFetch;
                    end
                end
                StFetch: begin
                    if (issue) begin
                        // Index wraps naturally in IW bits for critical-word-first order.
                        rd_idx_q <= rd_idx_q + IW'(1);
                        issued_q <= issued_q + IW'(1);
                        if (issued_q == IW'(LINE_WORDS - 1)) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (pop && last_beat) begin
                        state_q <= StAck;
                    end
                end
                StAck: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Return path: latency tracker feeding the beat FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_vld_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(MEM_LAT); i++) begin
                sr_idx_q[i] <= '0;
            end
            for (int i = 0; i < int'(FD); i++) begin
                fifo_data_q[i] <= '0;
                fifo_idx_q[i]  <= '0;
            end
        end else begin
            for (int i = int'(MEM_LAT) - 1; i > 0; i--) begin
                sr_vld_q[i] <= sr_vld_q[i-1];
                sr_idx_q[i] <= sr_idx_q[i-1];
            end
            sr_vld_q[0] <= issue;
            sr_idx_q[0] <= rd_idx_q;
            if (push) begin
                fifo_data_q[wr_ptr_q] <= bus.mem_rdata_i;
                fifo_idx_q[wr_ptr_q]  <= sr_idx_q[MEM_LAT-1];
                wr_ptr_q              <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end
endmodule
